// File: rtl/opcodes.sv
// Shared decoded-opcode definitions plus the control-flow helpers used by
// hazard_scoreboard.
package opcodes;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_MUL, OP_DIV,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR
  } opcode_out_t;

  localparam int BR_DECODE_BUBBLE = 0;
  localparam int BR_PREDICT_NT    = 1;

  function automatic logic is_control_flow(opcode_out_t op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_scoreboard.sv
// Per-register busy bits and outstanding-write counter. When one register is
// set and cleared on the same edge, the set wins.
module reg_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int IDX_W           = $clog2(NUM_REGS),
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    clr_idx,
  output logic                clr_hit,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    outstanding
);

  logic [NUM_REGS-1:0] busy_nxt;

  assign clr_hit = clr_en & busy_vec[clr_idx];

  always_comb begin
    busy_nxt = busy_vec;
    if (clr_hit) busy_nxt[clr_idx] = 1'b0;
    if (set_en)  busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      outstanding <= '0;
    end else begin
      busy_vec <= busy_nxt;
      if (set_en && !clr_hit)
        outstanding <= outstanding + CNT_W'(1);
      else if (clr_hit && !set_en)
        outstanding <= outstanding - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: RAW/WAW/structural stalls against the long-latency
// scoreboard, plus EX redirect and optional decode-bubble branch handling.
module hazard_scoreboard
  import opcodes::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int IDX_W           = $clog2(NUM_REGS),
  parameter int MAX_OUTSTANDING = 4,
  parameter int BRANCH_MODE     = 1,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 id_valid,
  input  opcode_out_t                          id_opcode,
  input  logic [IDX_W-1:0]                     id_rs1_idx,
  input  logic [IDX_W-1:0]                     id_rs2_idx,
  input  logic                                 id_rs1_used,
  input  logic                                 id_rs2_used,
  input  logic [IDX_W-1:0]                     id_rd_idx,
  input  logic                                 id_rd_we,
  input  logic                                 id_long_lat,
  input  logic                                 ex_redirect,
  input  logic                                 wb_valid,
  input  logic [IDX_W-1:0]                     wb_idx,
  output logic                                 fe_enable,
  output logic                                 ifid_clear,
  output logic                                 idex_clear,
  output logic                                 id_issue,
  output logic [NUM_REGS-1:0]                  busy_vec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [STALL_CNT_W-1:0]               stall_count,
  output logic                                 err_spurious_wb
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic clr_hit, set_en, rd_nz;
  logic eb_rs1, eb_rs2, eb_rd;
  logic raw_haz, waw_haz, struct_haz, stall, br_bubble;

  // Effective busy forwards a same-cycle writeback, so it never stalls.
  assign eb_rs1 = (id_rs1_idx != '0) & busy_vec[id_rs1_idx] & ~(wb_valid & (wb_idx == id_rs1_idx));
  assign eb_rs2 = (id_rs2_idx != '0) & busy_vec[id_rs2_idx] & ~(wb_valid & (wb_idx == id_rs2_idx));
  assign eb_rd  = (id_rd_idx  != '0) & busy_vec[id_rd_idx]  & ~(wb_valid & (wb_idx == id_rd_idx));
  assign rd_nz  = (id_rd_idx != '0);

  assign raw_haz    = id_valid & ((id_rs1_used & eb_rs1) | (id_rs2_used & eb_rs2));
  assign waw_haz    = id_valid & id_rd_we & eb_rd;
  assign struct_haz = id_valid & id_long_lat & id_rd_we & rd_nz &
                      ((outstanding - CNT_W'(clr_hit)) == CNT_W'(MAX_OUTSTANDING));
  assign stall      = raw_haz | waw_haz | struct_haz;
  assign br_bubble  = (BRANCH_MODE == BR_DECODE_BUBBLE) && is_control_flow(id_opcode);

  always_comb begin
    fe_enable  = 1'b1;
    ifid_clear = 1'b0;
    idex_clear = 1'b0;
    id_issue   = 1'b0;
    if (ex_redirect) begin
      ifid_clear = 1'b1;
      idex_clear = 1'b1;
    end else if (stall) begin
      fe_enable  = 1'b0;
      idex_clear = 1'b1;
    end else begin
      id_issue = id_valid;
      if (id_valid && br_bubble) begin
        ifid_clear = 1'b1;
        fe_enable  = 1'b0;
      end
    end
  end

  assign set_en = id_issue & id_long_lat & id_rd_we & rd_nz;

  reg_scoreboard #(
    .NUM_REGS        (NUM_REGS),
    .IDX_W           (IDX_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (set_en),
    .set_idx     (id_rd_idx),
    .clr_en      (wb_valid),
    .clr_idx     (wb_idx),
    .clr_hit     (clr_hit),
    .busy_vec    (busy_vec),
    .outstanding (outstanding)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count     <= '0;
      err_spurious_wb <= 1'b0;
    end else begin
      if (!ex_redirect && stall && (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_W'(1);
      if (wb_valid && !busy_vec[wb_idx])
        err_spurious_wb <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard; a decode-bubble and a
// predict-not-taken instance share the same stimulus.
module tb_hazard_scoreboard;
  import opcodes::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long_lat;
  opcode_out_t id_opcode;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx, wb_idx;
  logic        ex_redirect, wb_valid;

  logic        fe0, ifc0, idc0, iss0, err0;
  logic        fe1, ifc1, idc1, iss1, err1;
  logic [31:0] busy0, busy1;
  logic [2:0]  out0, out1;
  logic [15:0] sc0, sc1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.BRANCH_MODE(BR_DECODE_BUBBLE)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we),
    .id_long_lat(id_long_lat), .ex_redirect(ex_redirect), .wb_valid(wb_valid),
    .wb_idx(wb_idx), .fe_enable(fe0), .ifid_clear(ifc0), .idex_clear(idc0),
    .id_issue(iss0), .busy_vec(busy0), .outstanding(out0), .stall_count(sc0),
    .err_spurious_wb(err0));

  hazard_scoreboard #(.BRANCH_MODE(BR_PREDICT_NT)) dut_nt (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we),
    .id_long_lat(id_long_lat), .ex_redirect(ex_redirect), .wb_valid(wb_valid),
    .wb_idx(wb_idx), .fe_enable(fe1), .ifid_clear(ifc1), .idex_clear(idc1),
    .id_issue(iss1), .busy_vec(busy1), .outstanding(out1), .stall_count(sc1),
    .err_spurious_wb(err1));

  typedef struct {
    logic        valid;
    opcode_out_t opc;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        ll;
    logic        redir;
    logic        wbv;
    logic [4:0]  wbi;
    logic        x_fe0, x_ifc0, x_idc, x_iss, x_fe1, x_ifc1;
    logic [31:0] x_busy;
    logic [2:0]  x_out;
    logic [15:0] x_sc;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic v, opcode_out_t o, logic [4:0] r1, logic a1, logic [4:0] r2, logic a2,
    logic [4:0] d, logic w, logic l, logic rdr, logic wv, logic [4:0] wi,
    logic f0, logic c0, logic dc, logic is, logic f1, logic c1,
    logic [31:0] b, logic [2:0] ot, logic [15:0] s, logic e);
    vec_t t;
    t.valid = v; t.opc = o; t.rs1 = r1; t.u1 = a1; t.rs2 = r2; t.u2 = a2;
    t.rd = d; t.we = w; t.ll = l; t.redir = rdr; t.wbv = wv; t.wbi = wi;
    t.x_fe0 = f0; t.x_ifc0 = c0; t.x_idc = dc; t.x_iss = is; t.x_fe1 = f1; t.x_ifc1 = c1;
    t.x_busy = b; t.x_out = ot; t.x_sc = s; t.x_err = e;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = OP_NOP; id_rs1_idx = 0; id_rs2_idx = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_idx = 0; id_rd_we = 0;
    id_long_lat = 0; ex_redirect = 0; wb_valid = 0; wb_idx = 0;
  endtask

  initial begin
    //                 v  opc      rs1 u1 rs2 u2 rd we ll rd wv wi  fe0 ic0 idc iss fe1 ic1  busy        out sc err
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h20, 1, 0, 0));
    tbl.push_back(mk(1, OP_ALU,   5, 1, 0, 0,10, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 32'h20, 1, 1, 0));
    tbl.push_back(mk(1, OP_ALU,   5, 1, 0, 0,10, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 32'h20, 1, 2, 0));
    tbl.push_back(mk(1, OP_ALU,   5, 1, 0, 0,10, 1, 0, 0, 1, 5,  1, 0, 0, 1, 1, 0, 32'h0,  0, 2, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h2,  1, 2, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 2, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h6,  2, 2, 0));
    tbl.push_back(mk(1, OP_MUL,   0, 0, 0, 0, 3, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'hE,  3, 2, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 4, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h1E, 4, 2, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 32'h1E, 4, 3, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 6, 1, 1, 0, 1, 2,  1, 0, 0, 1, 1, 0, 32'h5A, 4, 3, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 0, 32'h58, 3, 3, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  1, 0, 0, 0, 1, 0, 32'h50, 2, 3, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  1, 0, 0, 0, 1, 0, 32'h40, 1, 3, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  1, 0, 0, 0, 1, 0, 32'h0,  0, 3, 0));
    tbl.push_back(mk(1, OP_DIV,   0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h80, 1, 3, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 32'h80, 1, 4, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 7, 1, 1, 0, 1, 7,  1, 0, 0, 1, 1, 0, 32'h80, 1, 4, 0));
    tbl.push_back(mk(1, OP_ALU,   0, 0, 7, 1, 8, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 32'h80, 1, 5, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 7, 1, 8, 1, 1, 1, 0, 0,  1, 1, 1, 0, 1, 1, 32'h80, 1, 5, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  1, 0, 0, 0, 1, 0, 32'h0,  0, 5, 0));
    tbl.push_back(mk(1, OP_BEQ,   1, 1, 2, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 0, 32'h0,  0, 5, 0));
    tbl.push_back(mk(1, OP_JAL,   0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 0, 32'h0,  0, 5, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 32'h0,  0, 5, 0));
    tbl.push_back(mk(1, OP_LOAD,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 0, 32'h0,  0, 5, 0));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  1, 0, 0, 0, 1, 0, 32'h0,  0, 5, 1));
    tbl.push_back(mk(0, OP_NOP,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 32'h0,  0, 5, 1));

    idle();
    rst_n = 0;
    #12;
    check("reset_busy", busy0, 32'h0);
    check("reset_out", 32'(out0), 32'h0);
    check("reset_sc", 32'(sc0), 32'h0);
    check("reset_err", 32'(err0), 32'h0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      id_valid = tbl[i].valid; id_opcode = tbl[i].opc;
      id_rs1_idx = tbl[i].rs1; id_rs1_used = tbl[i].u1;
      id_rs2_idx = tbl[i].rs2; id_rs2_used = tbl[i].u2;
      id_rd_idx = tbl[i].rd; id_rd_we = tbl[i].we; id_long_lat = tbl[i].ll;
      ex_redirect = tbl[i].redir; wb_valid = tbl[i].wbv; wb_idx = tbl[i].wbi;
      #1;
      check($sformatf("v%0d fe_enable", i), 32'(fe0), 32'(tbl[i].x_fe0));
      check($sformatf("v%0d ifid_clear", i), 32'(ifc0), 32'(tbl[i].x_ifc0));
      check($sformatf("v%0d idex_clear", i), 32'(idc0), 32'(tbl[i].x_idc));
      check($sformatf("v%0d id_issue", i), 32'(iss0), 32'(tbl[i].x_iss));
      check($sformatf("v%0d nt_fe_enable", i), 32'(fe1), 32'(tbl[i].x_fe1));
      check($sformatf("v%0d nt_ifid_clear", i), 32'(ifc1), 32'(tbl[i].x_ifc1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy_vec", i), busy0, tbl[i].x_busy);
      check($sformatf("v%0d outstanding", i), 32'(out0), 32'(tbl[i].x_out));
      check($sformatf("v%0d stall_count", i), 32'(sc0), 32'(tbl[i].x_sc));
      check($sformatf("v%0d err_spurious_wb", i), 32'(err0), 32'(tbl[i].x_err));
      check($sformatf("v%0d nt_busy_vec", i), busy1, tbl[i].x_busy);
    end

    // Async reset in the middle of a RAW stall, away from any clock edge.
    @(negedge clk);
    idle();
    id_valid = 1; id_opcode = OP_LOAD; id_rd_idx = 12; id_rd_we = 1; id_long_lat = 1;
    @(negedge clk);
    id_opcode = OP_ALU; id_long_lat = 0; id_rd_idx = 13;
    id_rs1_idx = 12; id_rs1_used = 1;
    #1;
    check("pre_reset_stall", 32'(idc0), 32'h1);
    @(posedge clk);
    #1;
    check("pre_reset_busy", busy0, 32'h1000);
    check("pre_reset_sc", 32'(sc0), 32'h6);
    #2;
    rst_n = 0;
    #1;
    check("async_busy", busy0, 32'h0);
    check("async_out", 32'(out0), 32'h0);
    check("async_sc", 32'(sc0), 32'h0);
    check("async_err", 32'(err0), 32'h0);
    check("async_no_stall", 32'(fe0), 32'h1);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("post_reset_busy", busy0, 32'h0);
    check("post_reset_issue", 32'(iss0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
